// File: rtl/complex_butterfly_pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | complex_butterfly_pipe_if                                        |
// | Valid/ready operand and result bundle for the butterfly pipe.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface complex_butterfly_pipe_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
    logic           scale;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] sum;
    logic [2*W-1:0] diff;
    logic           out_sat;

    modport master (
        output in_valid, a, b, scale, out_ready,
        input  in_ready, out_valid, sum, diff, out_sat
    );

    modport slave (
        input  in_valid, a, b, scale, out_ready,
        output in_ready, out_valid, sum, diff, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/complex_butterfly_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | complex_butterfly_pipe                                           |
// | Two-stage radix-2 butterfly (a+b, a-b) with halve/saturate mode. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module complex_butterfly_pipe #(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    complex_butterfly_pipe_if.slave bus,
    input  wire logic               clr_stats,
    output logic                    ovf_sticky,
    output logic [CNT_W-1:0]        sat_count
);

    localparam logic signed [W:0] c_MAX = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] c_MIN = {2'b11, {(W-1){1'b0}}};

    typedef struct packed {
        logic         clamp;
        logic [W-1:0] val;
    } comp_t;

    // Halving drops the LSB of the W+1-bit value (floor); otherwise clamp to W bits.
    function automatic comp_t shape(input logic signed [W:0] x, input logic halve);
        comp_t r;
        r.clamp = 1'b0;
        r.val   = x[W-1:0];
        if (halve) begin
            r.val = x[W:1];
        end else if (x > c_MAX) begin
            r.clamp = 1'b1;
            r.val   = c_MAX[W-1:0];
        end else if (x < c_MIN) begin
            r.clamp = 1'b1;
            r.val   = c_MIN[W-1:0];
        end
        return r;
    endfunction

    logic                r_s1_valid;
    logic                r_s1_scale;
    logic signed [W:0]   r_s1_sr;
    logic signed [W:0]   r_s1_si;
    logic signed [W:0]   r_s1_dr;
    logic signed [W:0]   r_s1_di;

    logic                r_out_valid;
    logic [2*W-1:0]      r_sum;
    logic [2*W-1:0]      r_diff;
    logic                r_out_sat;
    logic                r_ovf_sticky;
    logic [CNT_W-1:0]    r_sat_count;

    logic                w_s2_en;
    logic                w_s1_en;
    logic                w_in_fire;
    logic                w_s2_load;
    logic [W-1:0]        w_ar;
    logic [W-1:0]        w_ai;
    logic [W-1:0]        w_br;
    logic [W-1:0]        w_bi;
    comp_t               w_sr;
    comp_t               w_si;
    comp_t               w_dr;
    comp_t               w_di;
    logic                w_sat;

    // Handshake: a stage may advance when the stage after it is empty or draining.
    assign w_s2_en   = !r_out_valid || bus.out_ready;
    assign w_s1_en   = !r_s1_valid || w_s2_en;
    assign w_in_fire = bus.in_valid && w_s1_en;
    assign w_s2_load = w_s2_en && r_s1_valid;

    assign w_ar = bus.a[2*W-1:W];
    assign w_ai = bus.a[W-1:0];
    assign w_br = bus.b[2*W-1:W];
    assign w_bi = bus.b[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_scale <= 1'b0;
            r_s1_sr    <= '0;
            r_s1_si    <= '0;
            r_s1_dr    <= '0;
            r_s1_di    <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= w_in_fire;
            if (w_in_fire) begin
                r_s1_scale <= bus.scale;
                r_s1_sr    <= {w_ar[W-1], w_ar} + {w_br[W-1], w_br};
                r_s1_si    <= {w_ai[W-1], w_ai} + {w_bi[W-1], w_bi};
                r_s1_dr    <= {w_ar[W-1], w_ar} - {w_br[W-1], w_br};
                r_s1_di    <= {w_ai[W-1], w_ai} - {w_bi[W-1], w_bi};
            end
        end
    end

    always_comb begin
        w_sr  = shape(r_s1_sr, r_s1_scale);
        w_si  = shape(r_s1_si, r_s1_scale);
        w_dr  = shape(r_s1_dr, r_s1_scale);
        w_di  = shape(r_s1_di, r_s1_scale);
        w_sat = w_sr.clamp | w_si.clamp | w_dr.clamp | w_di.clamp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_diff      <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum     <= {w_sr.val, w_si.val};
                r_diff    <= {w_dr.val, w_di.val};
                r_out_sat <= w_sat;
            end
        end
    end

    // A clear coinciding with a saturating load keeps that load's event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
            r_sat_count  <= '0;
        end else if (clr_stats) begin
            r_ovf_sticky <= w_s2_load && w_sat;
            r_sat_count  <= (w_s2_load && w_sat) ? CNT_W'(1) : '0;
        end else if (w_s2_load && w_sat) begin
            r_ovf_sticky <= 1'b1;
            if (r_sat_count != {CNT_W{1'b1}}) begin
                r_sat_count <= r_sat_count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = w_s1_en;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.diff      = r_diff;
    assign bus.out_sat   = r_out_sat;
    assign ovf_sticky    = r_ovf_sticky;
    assign sat_count     = r_sat_count;

endmodule
`default_nettype wire

// File: doc/complex_butterfly_pipe.md
Name: complex_butterfly_pipe

Overview:
- Parametrised, pipelined complex add/subtract unit.
- Successor to the combinational complex subtractor.
- Computes the radix-2 butterfly pair sum = a+b and diff = a−b in one pass.
- Per-transaction mode selects either halving (FFT stage scaling) or saturation.
- Valid/ready handshake with full backpressure; sits between the FFT twiddle multiplier and the stage memory.

Parameters:
- W, 16, width of each real/imag component (two's complement).
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input this cycle.
- a  in  2W  operand A, packed {real, imag}, real in upper W bits.
- b  in  2W  operand B, same packing.
- scale  in  1  sampled with the transaction: 1 = halve results, 0 = saturate results.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  2W  {real, imag} of a+b.
- diff  out  2W  {real, imag} of a−b.
- out_sat  out  1  at least one component of this result was clamped.
- ovf_sticky  out  1  sticky: any saturation since reset or clear.
- sat_count  out  CNT_W  count of saturated transactions; holds at all-ones.
- clr_stats  in  1  synchronous clear of ovf_sticky and sat_count.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid, out_valid, out_sat, ovf_sticky = 0; sat_count = 0.
  - sum and diff registers = 0.
  - in_ready reads 1 once reset is released.
- Two-stage pipeline; latency is 2 cycles from accepted input to out_valid with no stall.
- Stage 1 (S1): on accept, registers four W+1-bit sign-extended results (ar+br, ai+bi, ar−br, ai−bi) plus scale.
- Stage 2 (S2): on load, applies scaling or saturation, registers sum, diff and out_sat.
- Handshake:
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en; this is a combinational path from out_ready and is permitted.
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - When S2 is enabled, S1 contents move to S2 and out_valid <= s1_valid.
  - S1 loads new input, or clears s1_valid if no input is transferring.
  - Holding out_ready low with the pipe full gives in_ready=0 and no data loss.
  - sum, diff and out_sat stay stable while out_valid && !out_ready.
  - Throughput is 1 transaction/cycle when out_ready is held high.
- Arithmetic, per component x of W+1 bits:
  - scale=1: result = x[W:1], an arithmetic shift right. It truncates toward −inf and never saturates.
  - scale=0: if x > 2^(W−1)−1, result = 2^(W−1)−1. If x < −2^(W−1), result = −2^(W−1). Otherwise result = x[W−1:0].
  - out_sat = OR of the four clamp events for that transaction.
- Statistics update only on an S2 load of a valid transaction:
  - If out_sat is set, ovf_sticky <= 1 and sat_count increments, saturating at 2^CNT_W−1.
  - clr_stats alone: ovf_sticky <= 0, sat_count <= 0.
  - clr_stats in the same cycle as a saturating load: ovf_sticky = 1, sat_count = 1.
- Reset mid-operation discards all in-flight transactions immediately.
- After reset release, no stale out_valid appears.

Test Plan:
- W=16, scale=0, a=(16383,16383), b=(16383,16383) → after 2 cycles sum=(32766,32766), diff=(0,0), out_sat=0, sat_count=0.
- scale=0, a=(16383,−16384), b=(−16384,16383) → sum=(−1,−1), diff=(32767,−32767), out_sat=0.
- scale=0, a=(32767,−32768), b=(1,1) → sum=(32767,−32767), diff=(32766,−32768), out_sat=1, ovf_sticky=1, sat_count=1. Same operands with scale=1 → sum=(16384,−16384), diff=(16383,−16385), out_sat=0.
- scale=0, a=(−32768,0), b=(−32768,0) → sum=(−32768,0) sat, diff=(0,0). Then pulse clr_stats → ovf_sticky=0, sat_count=0. Clear coincident with a saturating load → sat_count=1.
- Backpressure: hold out_ready=0, drive 4 back-to-back inputs → exactly 2 accepted, then in_ready=0. Release out_ready → all 4 results emerge in order, none dropped or duplicated, outputs stable while stalled.
- Stream 10 transactions with out_ready=1 → 1 result/cycle, first at cycle 2. Assert rst_n low mid-stream → out_valid=0 asynchronously, sat_count=0, no residual output after release.
